// File: rtl/aes_pkg.sv
// Shared types and constants for the AES key-expansion arbiter.
//   state_t : arbiter FSM states
//   block_t : 128-bit key/data block
//   REQ_ECU / REQ_DCU : requester indices (encryption / decryption controller)
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef logic [127:0] block_t;

  localparam logic REQ_ECU = 1'b0;
  localparam logic REQ_DCU = 1'b1;

endpackage

// File: rtl/aes_kx_watchdog.sv
// Watchdog counter for one key-expansion run.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset
//   i_clr    : clear count to zero (wins over i_en)
//   i_en     : count one cycle
//   o_expire : high while enabled and the count has reached TIMEOUT-1
module aes_kx_watchdog #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at LIMIT so a stalled owner can never wrap back to a safe count.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/aes_kx_arbiter.sv
// Round-robin arbiter/sequencer for the shared AES key-expansion unit.
// Requester 0 is the encryption controller, requester 1 the decryption controller.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_req[1:0]        : per-requester ownership request (level)
//   i_req_start[1:0]  : per-requester start_key_exp (level)
//   i_req_key/data    : per-requester 128-bit blocks, [127:0] = ECU, [255:128] = DCU
//   o_grant[1:0]      : one-hot owner, 00 when idle
//   o_req_done[1:0]   : key_expanded routed to the owner only
//   o_err             : one-cycle pulse on watchdog timeout
//   o_kx_start/key/data/abort, i_kx_expanded : expander interface
module aes_kx_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_req,
  input  logic [1:0]   i_req_start,
  input  logic [255:0] i_req_key,
  input  logic [255:0] i_req_data,
  output logic [1:0]   o_grant,
  output logic [1:0]   o_req_done,
  output logic         o_err,
  output logic         o_kx_start,
  output logic [127:0] o_kx_key,
  output logic [127:0] o_kx_data,
  output logic         o_kx_abort,
  input  logic         i_kx_expanded
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t r_state, w_state_d;
  logic   r_owner, w_owner_d;
  logic   r_rr, w_rr_d;     // requester served last; the other one wins a tie
  logic   r_start_q;        // owner's start from the previous cycle, for HOLD re-start

  logic   w_own_req, w_own_start;
  block_t w_own_key, w_own_data;
  logic   w_in_run, w_expire;
  logic   w_done, w_abort, w_err;

  assign w_own_req   = r_owner ? i_req[REQ_DCU]       : i_req[REQ_ECU];
  assign w_own_start = r_owner ? i_req_start[REQ_DCU] : i_req_start[REQ_ECU];
  assign w_own_key   = r_owner ? i_req_key[255:128]   : i_req_key[127:0];
  assign w_own_data  = r_owner ? i_req_data[255:128]  : i_req_data[127:0];
  assign w_in_run    = (r_state == RUN);

  // Count restarts from zero on every entry into RUN.
  aes_kx_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (!w_in_run),
    .i_en     (w_in_run),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_rr_d    = r_rr;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req != 2'b00) begin
          w_owner_d = (i_req == 2'b11) ? ~r_rr : i_req[REQ_DCU];
          w_state_d = GRANT;
        end
      end
      GRANT: begin
        if (!w_own_req) begin
          w_state_d = IDLE;
          w_rr_d    = r_owner;
        end else if (w_own_start) begin
          w_state_d = RUN;
        end
      end
      RUN: begin
        // Completion beats a same-cycle release or timeout.
        if (i_kx_expanded) begin
          w_done    = 1'b1;
          w_state_d = HOLD;
        end else if (!w_own_req) begin
          w_abort   = 1'b1;
          w_state_d = IDLE;
          w_rr_d    = r_owner;
        end else if (w_expire) begin
          w_abort   = 1'b1;
          w_err     = 1'b1;
          w_state_d = IDLE;
          w_rr_d    = r_owner;
        end
      end
      HOLD: begin
        if (!w_own_req) begin
          w_state_d = IDLE;
          w_rr_d    = r_owner;
        end else if (w_own_start && !r_start_q) begin
          w_state_d = RUN;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_owner   <= REQ_ECU;
      r_rr      <= REQ_DCU;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_owner   <= w_owner_d;
      r_rr      <= w_rr_d;
      r_start_q <= w_own_start;
    end
  end

  assign o_grant    = (r_state == IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
  assign o_req_done = w_done ? o_grant : 2'b00;
  // A reset in progress suppresses the abort/error pulses.
  assign o_kx_abort = w_abort && !i_rst;
  assign o_err      = w_err && !i_rst;
  // Start is masked in an abort cycle so the expander never sees both together.
  assign o_kx_start = w_in_run && w_own_start && !w_abort;
  assign o_kx_key   = (r_state == IDLE) ? '0 : w_own_key;
  assign o_kx_data  = (r_state == IDLE) ? '0 : w_own_data;

endmodule

// File: doc/aes_kx_arbiter.md
Name: aes_kx_arbiter

Overview:
Arbiter and sequencer for the shared AES key-expansion unit in the core. Two controllers request the expander: requester 0 is the encryption controller, requester 1 is the decryption controller (DCU). The block grants one requester at a time with round-robin fairness and muxes that owner's start, key and data onto the expander. It routes completion back to the owner only, and aborts on a watchdog timeout.

Parameters:
TIMEOUT, 64, max cycles in RUN without kx_expanded before abort
CNT_W, $clog2(TIMEOUT+1), watchdog counter width (derived; not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  2  per-requester request; level, held for the whole ownership
req_start  in  2  per-requester start_key_exp; level, held until done
req_key  in  2x128  per-requester key (index 0 = ECU, 1 = DCU)
req_data  in  2x128  per-requester data
grant  out  2  one-hot owner indication; 00 when no owner
req_done  out  2  key_expanded routed to the owner only
err  out  1  one-cycle pulse on watchdog timeout
kx_start  out  1  to expander: start_key_exp
kx_key  out  128  to expander: key
kx_data  out  128  to expander: data
kx_abort  out  1  to expander: one-cycle clear pulse
kx_expanded  in  1  from expander: key_expanded

Behaviour:
- Reset (rst high at a clk edge) drives all of the following:
  - grant=00, err=0, kx_abort=0, req_done=00, kx_start=0, kx_key=0, kx_data=0.
  - State goes to IDLE, watchdog count goes to 0, and the rr pointer is set so that ECU (0) wins the first tie.
  - rst overrides every other event. Reset mid-RUN does not pulse kx_abort.
- FSM states: IDLE, GRANT, RUN, HOLD.
- IDLE:
  - grant=00.
  - If exactly one req bit is high, that requester becomes owner.
  - If both are high, the requester not served last becomes owner.
  - Move to GRANT. grant is registered and goes high one cycle after req is sampled.
- GRANT:
  - If the owner drops req, go to IDLE with no abort.
  - If req_start[owner]=1, go to RUN and clear the watchdog count.
- RUN:
  - kx_start = req_start[owner]; kx_key/kx_data = owner inputs.
  - The watchdog increments every cycle.
  - If kx_expanded=1: req_done[owner]=1 combinationally in that cycle, then go to HOLD.
  - If the owner drops req before done: one-cycle kx_abort, go to IDLE, err=0.
  - If the count reaches TIMEOUT-1 without done: err=1 and kx_abort=1 for one cycle, go to IDLE.
  - If kx_expanded and the owner's req drop occur in the same cycle, done wins: req_done pulses and the FSM goes to HOLD, then to IDLE on the next cycle.
- HOLD:
  - kx_key/kx_data stay muxed from the owner so it can still sample them; kx_start=0.
  - When the owner drops req, go to IDLE.
  - A new rising req_start while in HOLD goes to RUN again with the count cleared (re-expansion without re-arbitration).
- Outputs outside RUN/HOLD:
  - kx_key/kx_data = 0 outside GRANT/RUN/HOLD.
  - kx_start = 0 outside RUN.
- Non-owner:
  - The non-owner's req_done is always 0.
  - The non-owner's inputs are ignored.
- rr pointer: updates to the owner on every exit from GRANT/RUN/HOLD to IDLE.
- Switch gap: an IDLE cycle always separates two ownerships, so minimum turnaround is 2 cycles from release to the next grant.
- Abort timing: kx_abort is never asserted in the same cycle as kx_start.

Decomposition:
- Shared package aes_pkg holds:
  - typedef state_t {IDLE, GRANT, RUN, HOLD}
  - typedef block_t = logic[127:0]
  - localparams REQ_ECU=0, REQ_DCU=1
- One sub-module: aes_kx_watchdog. It is a CNT_W counter with clear/enable inputs and an expire output.
- The FSM, rr pointer and mux stay in the top level.

Test Plan:
1. Single DCU request:
   - Stimulus: req=10, req_start[1]=1, req_key[1]=128'habab...ab; kx_expanded=1 after 10 cycles.
   - Required: grant=10 one cycle after req; kx_key=abab...ab; req_done=10 in the same cycle as kx_expanded; grant=00 one cycle after req drops.
2. Tie after reset:
   - Stimulus: req=11.
   - Required: ECU is granted first (grant=01); after ECU releases, one IDLE cycle, then grant=10; the next tie goes to ECU again.
3. Timeout:
   - Stimulus: owner holds req_start with no kx_expanded, TIMEOUT=64.
   - Required: err=1 and kx_abort=1 on the 64th RUN cycle; grant=00 the next cycle; the other pending requester is granted after that.
4. Owner release mid-RUN:
   - Stimulus: req[0] drops in RUN cycle 5.
   - Required: kx_abort pulses for 1 cycle, err=0, kx_start goes to 0.
5. Simultaneous done and release:
   - Stimulus: kx_expanded=1 and req[1]=0 in the same cycle.
   - Required: req_done[1]=1, no abort, IDLE two cycles later.
6. Reset mid-RUN:
   - Stimulus: rst=1 for 1 cycle during RUN.
   - Required: all outputs are 0 at the next edge, kx_abort=0, and the ECU-first tie priority is restored.
